// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: single-outstanding instruction prefetcher feeding a FIFO of {pc, instr}
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic          issue;
    logic          push;
    logic          pop;

    // Issue is judged on the pre-pop count so a returning word always finds room
    assign issue       = rst_n && state == IDLE && count < CW'(DEPTH) && !redirect;
    assign push        = state == WAIT && imem_ack && !redirect;
    assign pop         = instr_valid && instr_ready && !redirect;
    assign imem_req    = issue || state != IDLE;
    assign imem_addr   = state == IDLE ? fetch_pc : req_addr;
    assign instr_valid = count != '0;
    assign instr       = instr_valid ? ins_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr] : '0;

    // Fetch controller, queue pointers and fetch PC; redirect flushes and retargets
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (redirect) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (push) fetch_pc <= req_addr + 32'd4;
            end
            case (state)
                IDLE: if (issue) begin
                    state    <= WAIT;
                    req_addr <= fetch_pc;
                end
                WAIT: if (imem_ack) state <= IDLE;
                      else if (redirect) state <= DROP;
                DROP: if (imem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Queue storage; outputs are masked while empty so no reset is needed here
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= req_addr;
            ins_mem[wr_ptr] <= imem_data;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed and random checks of the fetch queue against a queue-level model
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack, instr_valid, instr_ready, redirect;
    logic [31:0] imem_addr, imem_data, instr, instr_pc, redirect_pc;
    logic        req2, valid2;
    logic [31:0] addr2, instr2, pc2;

    int n_chk = 0;
    int n_fail = 0;

    bit [63:0]   q[$];
    bit          out, drop;
    logic [31:0] fpc, raddr;

    int          d2 = -1;
    logic [31:0] a2 [7] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h4};
    logic        v2 [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] p2 [7] = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0};

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(1'b1), .imem_data(32'h1234_5678), .instr(instr2), .instr_pc(pc2),
        .instr_valid(valid2), .instr_ready(1'b1), .redirect(1'b0),
        .redirect_pc(32'h0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        out = 0;
        drop = 0;
        fpc = 32'h0;
        raddr = 32'h0;
    endtask

    task automatic model_update();
        bit          idle, iss, a;
        logic [31:0] nf;
        if (!rst_n) begin
            model_reset();
            return;
        end
        idle = !out && !drop;
        a = imem_ack;
        nf = fpc;
        iss = idle && q.size() < DEPTH && !redirect;
        if (redirect) begin
            q.delete();
            nf = {redirect_pc[31:2], 2'b00};
        end else begin
            if (q.size() != 0 && instr_ready) q.delete(0);
            if (out && a) begin
                q.push_back({raddr, imem_data});
                nf = raddr + 32'd4;
            end
        end
        if (iss) begin
            out = 1;
            raddr = fpc;
        end else if (out && a) out = 0;
        else if (out && redirect) begin
            out = 0;
            drop = 1;
        end else if (drop && a) drop = 0;
        fpc = nf;
    endtask

    task automatic check_model();
        bit busy, exp_req, exp_valid;
        busy = out || drop;
        exp_req = rst_n && (busy || (q.size() < DEPTH && !redirect));
        exp_valid = rst_n && q.size() != 0;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, busy ? raddr : fpc);
        chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
        chk("instr", instr, exp_valid ? q[0][31:0] : 32'h0);
        chk("instr_pc", instr_pc, exp_valid ? q[0][63:32] : 32'h0);
    endtask

    task automatic drive(input bit rn, input bit r, input logic [31:0] rpc, input bit rdy, input int am);
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst_n = rn;
        redirect = r;
        redirect_pc = rpc;
        instr_ready = rdy;
        imem_ack = am == 0 ? 1'b0 : am == 1 ? 1'b1 : am == 2 ? (out || drop) : ($urandom_range(0, 2) != 0);
        imem_data = am == 3 ? $urandom : raddr ^ 32'hA5A5_0000;
        #1;
        check_model();
        if (d2 >= 0 && d2 < 7) begin
            chk("d2_req", 32'(req2), 32'h1);
            chk("d2_addr", addr2, a2[d2]);
            chk("d2_valid", 32'(valid2), 32'(v2[d2]));
            if (v2[d2]) chk("d2_pc", pc2, p2[d2]);
            d2++;
        end
    endtask

    initial begin
        redirect = 0;
        redirect_pc = 0;
        instr_ready = 0;
        imem_ack = 0;
        imem_data = 0;
        model_reset();
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        d2 = 0;
        drive(1, 0, 0, 0, 2);
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        repeat (9) drive(1, 0, 0, 0, 2);
        chk("full_req", 32'(imem_req), 32'h0);
        chk("full_valid", 32'(instr_valid), 32'h1);
        chk("full_instr", instr, 32'hA5A5_0000);
        chk("full_pc", instr_pc, 32'h0);
        drive(1, 0, 0, 1, 2);
        drive(1, 0, 0, 0, 2);
        chk("pop_pc", instr_pc, 32'h4);
        chk("refill_req", 32'(imem_req), 32'h1);
        chk("refill_addr", imem_addr, 32'h10);
        drive(0, 0, 0, 0, 0);
        repeat (5) drive(1, 0, 0, 0, 2);
        chk("pre_redir_addr", imem_addr, 32'h8);
        drive(1, 1, 32'h103, 0, 0);
        chk("wait_addr", imem_addr, 32'h8);
        drive(1, 0, 0, 0, 1);
        chk("drop_req", 32'(imem_req), 32'h1);
        chk("drop_addr", imem_addr, 32'h8);
        chk("drop_valid", 32'(instr_valid), 32'h0);
        drive(1, 0, 0, 0, 2);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid", 32'(instr_valid), 32'h0);
        drive(1, 0, 0, 0, 2);
        drive(1, 0, 0, 0, 2);
        chk("redir_pc", instr_pc, 32'h100);
        chk("redir_instr", instr, 32'hA5A5_0100);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 32'h200, 0, 1);
        drive(1, 0, 0, 0, 0);
        chk("coll_valid", 32'(instr_valid), 32'h0);
        chk("coll_req", 32'(imem_req), 32'h1);
        chk("coll_addr", imem_addr, 32'h200);
        drive(1, 0, 0, 0, 0);
        rst_n = 0;
        drive(0, 0, 0, 0, 0);
        chk("rst_mid_req", 32'(imem_req), 32'h0);
        chk("rst_mid_valid", 32'(instr_valid), 32'h0);
        drive(0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 1);
        chk("post_req", 32'(imem_req), 32'h1);
        chk("post_addr", imem_addr, 32'h0);
        drive(1, 0, 0, 0, 0);
        chk("post_valid", 32'(instr_valid), 32'h0);
        chk("post_wait_addr", imem_addr, 32'h0);
        for (int i = 0; i < 400; i++)
            drive(!(i >= 200 && i < 202), $urandom_range(0, 11) == 0, $urandom, 1'($urandom_range(0, 1)), 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of prefetch queue entries, power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-003 Clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Rst_n  in  1  asynchronous, active-low reset.
REQ-005 ImemReq  out  1  instruction memory request valid.
REQ-006 ImemAddr  out  32  instruction memory byte address, word aligned.
REQ-007 ImemAck  in  1  memory response strobe; data valid this cycle.
REQ-008 ImemData  in  32  instruction word returned with ImemAck.
REQ-009 Instr  out  32  instruction at queue head, to the datapath decode stage.
REQ-010 InstrPC  out  32  byte address of Instr, used by the datapath for PC+4 and branch targets.
REQ-011 InstrValid  out  1  queue head holds a valid entry.
REQ-012 InstrReady  in  1  datapath consumes head when InstrValid & InstrReady.
REQ-013 Redirect  in  1  one-cycle pulse: taken branch or jump, flush and refetch.
REQ-014 RedirectPC  in  32  new fetch address; bits [1:0] ignored, treated as 0.

Function
REQ-015 The queue SHALL be a FIFO of DEPTH entries, each {PC[31:0], instr[31:0]}, with Instr/InstrPC driven combinationally from the head entry.
REQ-016 At most one memory request SHALL be outstanding; the controller SHALL have states IDLE, WAIT, DROP.
REQ-017 IDLE: ImemReq=1 with ImemAddr=fetch PC only when count < DEPTH and Redirect=0; on issue the state SHALL become WAIT.
REQ-018 Issue SHALL require count < DEPTH evaluated before the same-cycle pop, so no accepted response ever finds the queue full.
REQ-019 WAIT: ImemReq and ImemAddr SHALL stay stable until ImemAck; on ImemAck the word SHALL be pushed with PC=ImemAddr, fetch PC SHALL advance by 4 (modulo 2^32, FFFF_FFFC wraps to 0), and the state SHALL return to IDLE.
REQ-020 Memory latency SHALL be arbitrary (ImemAck may assert in the issue cycle's next edge or any later cycle); zero-wait memory SHALL sustain one push every two cycles.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged; pop on empty SHALL have no effect.
REQ-022 Redirect SHALL, on the same edge, empty the queue (InstrValid=0 next cycle) and load fetch PC = {RedirectPC[31:2],2'b00}.
REQ-023 Redirect in IDLE SHALL suppress issue that cycle; the new address SHALL be issued the following cycle.
REQ-024 Redirect in WAIT without ImemAck SHALL move to DROP; DROP SHALL hold the old ImemReq/ImemAddr until ImemAck, discard that word, then go to IDLE.
REQ-025 Redirect coinciding with ImemAck SHALL discard the returned word and go to IDLE.
REQ-026 Redirect in DROP SHALL only update fetch PC; state remains DROP.
REQ-027 Redirect takes priority over a same-cycle pop; the popped head is still considered consumed by the datapath.

Reset
REQ-028 While Rst_n=0: state=IDLE, count=0, read/write pointers=0, fetch PC=RESET_PC, ImemReq=0, InstrValid=0; Instr and InstrPC SHALL read 0.
REQ-029 First ImemReq SHALL assert in the first cycle after Rst_n deasserts, ImemAddr=RESET_PC.
REQ-030 Reset asserted mid-transaction SHALL abandon the outstanding request; a stale ImemAck after reset release while in IDLE SHALL be ignored.

Verification
REQ-031 Reset release, 1-cycle-latency memory returning addr^32'hA5A5_0000, InstrReady=0 -> 4 requests at 0,4,8,C, then ImemReq stays 0; InstrValid=1, Instr=A5A5_0000, InstrPC=0.
REQ-032 Full queue, InstrReady pulsed once -> head advances to InstrPC=4, one new request at 0x10 next cycle.
REQ-033 Request to 0x8 outstanding, Redirect with RedirectPC=0x103 -> stale ack discarded, next request at 0x100, first Instr after redirect has InstrPC=0x100.
REQ-034 Redirect and ImemAck same cycle -> word not enqueued, InstrValid=0 next cycle, next ImemAddr=RedirectPC.
REQ-035 RESET_PC=FFFF_FFF8, InstrReady=1 -> requests FFFF_FFF8, FFFF_FFFC, 0000_0000; InstrPC sequence matches.
REQ-036 Rst_n driven low during WAIT with ack arriving 2 cycles later -> after release ImemReq at RESET_PC, late ack ignored, queue empty.
